// File: rtl/avalon_ram_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : avalon_ram_slave_if
// Description : Avalon-MM bus bundle between a CPU master and the RAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface avalon_ram_slave_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        protocol_error;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, protocol_error
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, protocol_error
    );
endinterface
`default_nettype wire

// File: rtl/avalon_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : avalon_ram_slave
// Description : Avalon-MM word RAM with programmable waitrequest stall,
//               byte-lane writes and registered read data. Optional bus
//               protocol checker enabled by AVALON_PROTOCOL_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  wire logic          clk,
    input  wire logic          reset,
    avalon_ram_slave_if.slave  bus
);
    localparam int          c_DEPTH        = 2 ** ADDR_BITS;
    localparam logic [32:0] c_WINDOW_BYTES = 33'(64'd4 << ADDR_BITS);
    localparam logic [63:0] c_WINDOW_END   = {32'd0, BASE_ADDR} + (64'd4 << ADDR_BITS);
    localparam logic [3:0]  c_WAIT         = 4'(WAIT_CYCLES);

    generate
        if (ADDR_BITS < 1 || ADDR_BITS > 30) begin : g_bad_addr_bits
            $fatal(1, "avalon_ram_slave: ADDR_BITS must lie in 1..30");
        end
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $fatal(1, "avalon_ram_slave: WAIT_CYCLES must lie in 0..15");
        end
        if (c_WINDOW_END > 64'h1_0000_0000) begin : g_bad_window
            $fatal(1, "avalon_ram_slave: address window wraps past 2**32");
        end
    endgenerate

    logic [31:0]          r_mem [c_DEPTH];
    logic [3:0]           r_cnt_q;
    logic [3:0]           w_cnt_d;
    logic [31:0]          r_readdata_q;
    logic [31:0]          w_readdata_d;
    logic                 w_pending;
    logic                 w_waitrequest;
    logic                 w_accept;
    logic [31:0]          w_offset;
    logic                 w_in_range;
    logic [ADDR_BITS-1:0] w_index;
    logic                 w_mem_we;
    logic                 w_unused_offset;

    // Address decode: unsigned offset from the window base; anything that
    // underflows lands far above the window and decodes as out of range.
    always_comb begin
        w_offset   = bus.address - BASE_ADDR;
        w_in_range = ({1'b0, w_offset} < c_WINDOW_BYTES);
        w_index    = w_offset[ADDR_BITS+1:2];
    end

    assign w_unused_offset = ^w_offset;

    always_comb begin
        w_pending     = bus.read | bus.write;
        w_waitrequest = reset | (w_pending & (r_cnt_q != c_WAIT));
        w_accept      = w_pending & ~w_waitrequest;
        w_mem_we      = w_accept & bus.write & w_in_range;
    end

    // Counter runs only while a request is being held off; acceptance or a
    // withdrawn request returns it to zero so the next transfer stalls fully.
    always_comb begin
        w_cnt_d = 4'd0;
        if (w_pending && w_waitrequest) begin
            w_cnt_d = r_cnt_q + 4'd1;
        end
    end

    always_comb begin
        w_readdata_d = r_readdata_q;
        if (w_accept && bus.read && !bus.write) begin
            w_readdata_d = w_in_range ? r_mem[w_index] : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_q      <= 4'd0;
            r_readdata_q <= 32'd0;
        end else begin
            r_cnt_q      <= w_cnt_d;
            r_readdata_q <= w_readdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byteenable[i]) begin
                    r_mem[w_index][8*i +: 8] <= bus.writedata[8*i +: 8];
                end
            end
        end
    end

    assign bus.waitrequest = w_waitrequest;
    assign bus.readdata    = r_readdata_q;

`ifdef AVALON_PROTOCOL_CHECK_EN
    logic        r_prev_stall_q;
    logic [31:0] r_prev_addr_q;
    logic [31:0] r_prev_wdata_q;
    logic        r_prev_rd_q;
    logic        r_prev_wr_q;
    logic [3:0]  r_prev_be_q;
    logic        r_perr_q;
    logic        w_perr_d;
    logic        w_err_rw;
    logic        w_err_align;
    logic        w_err_be;
    logic        w_err_chg;
    logic        w_viol;

    // A master must hold every request field steady while it is stalled.
    always_comb begin
        w_err_rw    = bus.read & bus.write;
        w_err_align = w_pending & (bus.address[1:0] != 2'b00);
        w_err_be    = bus.write & (bus.byteenable == 4'b0000);
        w_err_chg   = r_prev_stall_q &
                      ((bus.address    != r_prev_addr_q) |
                       (bus.read       != r_prev_rd_q)   |
                       (bus.write      != r_prev_wr_q)   |
                       (bus.byteenable != r_prev_be_q)   |
                       (r_prev_wr_q & (bus.writedata != r_prev_wdata_q)));
        w_viol      = ~reset & (w_err_rw | w_err_align | w_err_be | w_err_chg);
        w_perr_d    = r_perr_q | w_viol;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perr_q       <= 1'b0;
            r_prev_stall_q <= 1'b0;
        end else begin
            r_perr_q       <= w_perr_d;
            r_prev_stall_q <= w_pending & w_waitrequest;
        end
        r_prev_addr_q  <= bus.address;
        r_prev_wdata_q <= bus.writedata;
        r_prev_rd_q    <= bus.read;
        r_prev_wr_q    <= bus.write;
        r_prev_be_q    <= bus.byteenable;
        if (w_viol) begin
            $error("%0t avalon_ram_slave protocol violation: rd&wr=%b misaligned=%b no_be=%b changed_in_stall=%b",
                   $time, w_err_rw, w_err_align, w_err_be, w_err_chg);
        end
    end

    assign bus.protocol_error = r_perr_q;
`else
    assign bus.protocol_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_avalon_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_ram_slave
// Description : Scoreboard bench for avalon_ram_slave (WAIT_CYCLES=2 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_ram_slave;
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] data;
        int          lat;
    } item_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    item_t       sb1[$];
    logic [31:0] sb0[$];

    avalon_ram_slave_if bus1 ();
    avalon_ram_slave_if bus0 ();

    avalon_ram_slave #(.WAIT_CYCLES(2)) u_dut1 (.clk(clk), .reset(rst), .bus(bus1));
    avalon_ram_slave #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .reset(rst), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for the stalling instance.
    logic        m1_known = 1'b0;
    logic        m1_prst  = 1'b0;
    logic        m1_pacc  = 1'b0;
    logic [31:0] m1_pdata = 32'd0;
    logic [31:0] m1_exp   = 32'd0;
    int          m1_stall = 0;
    always @(negedge clk) begin
        item_t it;
        if (m1_prst) begin
            m1_exp   = 32'd0;
            m1_known = 1'b1;
        end else if (m1_pacc) begin
            m1_exp = m1_pdata;
        end
        if (m1_known) chk("readdata_w2", bus1.readdata, m1_exp);
        m1_prst = rst;
        m1_pacc = 1'b0;
        if (rst) begin
            chk("wait_in_reset", 32'(bus1.waitrequest), 32'd1);
            m1_stall = 0;
        end else if (bus1.read || bus1.write) begin
            if (bus1.waitrequest) begin
                m1_stall++;
            end else begin
                if (sb1.size() == 0) begin
                    chk("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    it = sb1.pop_front();
                    chk("latency", 32'(m1_stall), 32'(it.lat));
                    chk("kind", 32'({bus1.read, bus1.write}), 32'({it.rd, it.wr}));
                    if (it.rd && !it.wr) begin
                        m1_pacc  = 1'b1;
                        m1_pdata = it.data;
                    end
                end
                m1_stall = 0;
            end
        end else begin
            m1_stall = 0;
        end
`ifndef AVALON_PROTOCOL_CHECK_EN
        chk("perr_off_w2", 32'(bus1.protocol_error), 32'd0);
`endif
    end

    // Scoreboard monitor for the zero-wait instance.
    logic        m0_prst  = 1'b0;
    logic        m0_pacc  = 1'b0;
    logic [31:0] m0_pdata = 32'd0;
    always @(negedge clk) begin
        if (m0_prst) chk("reset_readdata_w0", bus0.readdata, 32'd0);
        if (m0_pacc) chk("readdata_w0", bus0.readdata, m0_pdata);
        m0_prst = rst;
        m0_pacc = 1'b0;
        if (!rst && (bus0.read || bus0.write)) begin
            chk("wait_w0", 32'(bus0.waitrequest), 32'd0);
            if (bus0.read && !bus0.write) begin
                if (sb0.size() == 0) begin
                    chk("unexpected_read_w0", 32'd1, 32'd0);
                end else begin
                    m0_pacc  = 1'b1;
                    m0_pdata = sb0.pop_front();
                end
            end
        end
    end

    task automatic wait_accept();
        int n;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!bus1.waitrequest) break;
        end
        if (n == 40) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Present a transfer at the start of a cycle and hold until accepted.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
        item_t it;
        @(posedge clk); #1;
        it.rd = rd; it.wr = wr; it.data = exp; it.lat = 2;
        sb1.push_back(it);
        bus1.read = rd; bus1.write = wr; bus1.address = addr;
        bus1.writedata = wd; bus1.byteenable = be;
        wait_accept();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus1.read = 1'b0; bus1.write = 1'b0;
        end
    endtask

    task automatic op(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
        issue(rd, wr, addr, wd, be, exp);
        idle(1);
    endtask

    localparam logic c_PE = `ifdef AVALON_PROTOCOL_CHECK_EN 1'b1 `else 1'b0 `endif;

    initial begin
        item_t it;
        vectors = 0; miscompares = 0;
        rst = 1'b1;
        bus1.read = 0; bus1.write = 0; bus1.address = 0; bus1.writedata = 0; bus1.byteenable = 0;
        bus0.read = 0; bus0.write = 0; bus0.address = 0; bus0.writedata = 0; bus0.byteenable = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Boot word, then full and partial-lane writes.
        op(0, 1, 32'hBFC0_0000, 32'h2402_0005, 4'hF, 32'h0);
        op(1, 0, 32'hBFC0_0000, 32'h0,         4'hF, 32'h2402_0005);
        op(0, 1, 32'hBFC0_0010, 32'hAABB_CCDD, 4'hF, 32'h0);
        op(0, 1, 32'hBFC0_0010, 32'h1122_3344, 4'b0101, 32'h0);
        op(1, 0, 32'hBFC0_0010, 32'h0,         4'h0, 32'hAA22_CC44);

        // Outside the window: zero read, dropped write.
        op(1, 0, 32'h0000_0100, 32'h0,         4'hF, 32'h0);
        op(0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0);
        op(1, 0, 32'hBFC0_0000, 32'h0,         4'hF, 32'h2402_0005);

        // Back-to-back reads: each stalls the full count.
        issue(1, 0, 32'hBFC0_0000, 32'h0, 4'hF, 32'h2402_0005);
        issue(1, 0, 32'hBFC0_0010, 32'h0, 4'hF, 32'hAA22_CC44);
        idle(1);

        // Write withdrawn after one stall cycle leaves memory untouched.
        @(posedge clk); #1;
        bus1.write = 1; bus1.address = 32'hBFC0_0010; bus1.writedata = 32'h0; bus1.byteenable = 4'hF;
        idle(2);
        op(1, 0, 32'hBFC0_0010, 32'h0, 4'hF, 32'hAA22_CC44);

        // Read+write together: write lands, readdata keeps its old value.
        op(1, 1, 32'hBFC0_0020, 32'h1234_5678, 4'hF, 32'h0);
        op(1, 0, 32'hBFC0_0020, 32'h0,         4'hF, 32'h1234_5678);

        // Window edges.
        op(0, 1, 32'hBFC0_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0);
        op(1, 0, 32'hBFC0_0FFC, 32'h0,         4'hF, 32'hCAFE_F00D);
        op(1, 0, 32'hBFC0_1000, 32'h0,         4'hF, 32'h0);
        op(1, 0, 32'hBFBF_FFFC, 32'h0,         4'hF, 32'h0);

        // Reset during the second stall cycle of a write.
        @(posedge clk); #1;
        it.rd = 0; it.wr = 1; it.data = 32'h0; it.lat = 2;
        sb1.push_back(it);
        bus1.read = 0; bus1.write = 1; bus1.address = 32'hBFC0_0020;
        bus1.writedata = 32'h5566_7788; bus1.byteenable = 4'hF;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        wait_accept();
        idle(1);
        op(1, 0, 32'hBFC0_0020, 32'h0, 4'hF, 32'h5566_7788);

        // Address changed mid-stall.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("perr_after_reset", 32'(bus1.protocol_error), 32'd0);
        @(posedge clk); #1;
        it.rd = 1; it.wr = 0; it.data = 32'hAA22_CC44; it.lat = 2;
        sb1.push_back(it);
        bus1.read = 1; bus1.address = 32'hBFC0_0000; bus1.byteenable = 4'hF;
        @(posedge clk); #1 bus1.address = 32'hBFC0_0010;
        wait_accept();
        chk("perr_set", 32'(bus1.protocol_error), 32'(c_PE));
        idle(3);
        @(negedge clk);
        chk("perr_sticky", 32'(bus1.protocol_error), 32'(c_PE));
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("perr_cleared", 32'(bus1.protocol_error), 32'd0);

        // Zero-wait instance: writes then a held read stream.
        bus0.byteenable = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus0.write = 1; bus0.address = 32'hBFC0_0000 + 32'(4 * i);
            bus0.writedata = (i == 0) ? 32'h1111_1111 : (i == 1) ? 32'h2222_2222 : 32'h3333_3333;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus0.write = 0; bus0.read = 1; bus0.address = 32'hBFC0_0000 + 32'(4 * i);
            sb0.push_back((i == 0) ? 32'h1111_1111 : (i == 1) ? 32'h2222_2222 : 32'h3333_3333);
        end
        @(posedge clk); #1 bus0.read = 0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        chk("sb0_drained", 32'(sb0.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
